// File: rtl/synapse_accum_engine.sv
// -----------------------------------------------------------------------------
// synapse_accum_engine
//   Pops spike addresses from a show-ahead FIFO and reads NUM_OUT consecutive
//   synapse weights per spike. Each weight is added into one of NUM_OUT
//   per-neuron saturating accumulators.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   i_start             begin a run (sampled only in IDLE)
//   i_fifo_data/valid   FIFO head (show-ahead) and non-empty flag
//   o_fifo_rden         pop strobe (combinational, CHECK state)
//   o_mem_addr/o_mem_en synapse memory read port (combinational, READ state)
//   i_mem_rdata         read data, valid one cycle after the address
//   o_sums              packed accumulators, channel k at [k*SUM_WIDTH +: SUM_WIDTH]
//   o_sat               sticky per-channel saturation flags
//   o_busy, o_done      not-IDLE indicator, one-cycle completion pulse
// -----------------------------------------------------------------------------
module synapse_accum_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 14,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int NUM_OUT        = 4,
    parameter int SUM_WIDTH      = 16,
    parameter int SIGNED_WEIGHTS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [ADDR_WIDTH-1:0]         i_fifo_data,
    input  logic                          i_fifo_valid,
    output logic                          o_fifo_rden,
    output logic [MEM_ADDR_WIDTH-1:0]     o_mem_addr,
    output logic                          o_mem_en,
    input  logic [DATA_WIDTH-1:0]         i_mem_rdata,
    output logic [NUM_OUT*SUM_WIDTH-1:0]  o_sums,
    output logic [NUM_OUT-1:0]            o_sat,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int KW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int EW = SUM_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_READ, S_DONE} state_t;

    state_t                    r_state;
    logic [KW-1:0]             r_k;
    logic [MEM_ADDR_WIDTH-1:0] r_base;
    logic                      r_tag_vld;
    logic [KW-1:0]             r_tag_k;

    logic                      w_pop;
    logic                      w_rd;
    logic                      w_last_k;
    logic                      w_clear;
    logic [MEM_ADDR_WIDTH-1:0] w_base;

    // Strobes are gated by rst so nothing is popped or read in a reset cycle.
    assign w_pop    = (r_state == S_CHECK) && i_fifo_valid && !rst;
    assign w_rd     = (r_state == S_READ) && !rst;
    assign w_last_k = (r_k == KW'(NUM_OUT - 1));
    assign w_clear  = (r_state == S_IDLE) && i_start;
    // Product taken modulo 2^MEM_ADDR_WIDTH; low bits depend only on low operand bits.
    assign w_base   = MEM_ADDR_WIDTH'(i_fifo_data) * MEM_ADDR_WIDTH'(NUM_OUT);

    assign o_fifo_rden = w_pop;
    assign o_mem_en    = w_rd;
    assign o_mem_addr  = w_rd ? (r_base + MEM_ADDR_WIDTH'(r_k)) : '0;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_base  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (i_fifo_valid) begin
                        r_base  <= w_base;
                        r_k     <= '0;
                        r_state <= S_READ;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_READ: begin
                    r_k <= r_k + KW'(1);
                    if (w_last_k) r_state <= S_CHECK;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag travels alongside the one-cycle memory latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= 1'b0;
            r_tag_k   <= '0;
        end else begin
            r_tag_vld <= w_rd;
            r_tag_k   <= r_k;
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
        logic [SUM_WIDTH-1:0] r_sum;
        logic                 r_sat;
        logic [EW-1:0]        w_wext;
        logic [EW-1:0]        w_sext;
        logic [EW-1:0]        w_add;
        logic                 w_ovf;
        logic [SUM_WIDTH-1:0] w_next;

        if (SIGNED_WEIGHTS != 0) begin : g_s
            // One guard bit: overflow when the top two bits disagree.
            always_comb begin
                w_wext = EW'($signed(i_mem_rdata));
                w_sext = {r_sum[SUM_WIDTH-1], r_sum};
                w_add  = w_sext + w_wext;
                w_ovf  = w_add[EW-1] ^ w_add[EW-2];
                w_next = w_add[SUM_WIDTH-1:0];
                if (w_ovf)
                    w_next = w_add[EW-1] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                                         : {1'b0, {(SUM_WIDTH-1){1'b1}}};
            end
        end else begin : g_u
            always_comb begin
                w_wext = EW'(i_mem_rdata);
                w_sext = {1'b0, r_sum};
                w_add  = w_sext + w_wext;
                w_ovf  = w_add[EW-1];
                w_next = w_ovf ? {SUM_WIDTH{1'b1}} : w_add[SUM_WIDTH-1:0];
            end
        end

        always_ff @(posedge clk) begin
            if (rst || w_clear) begin
                r_sum <= '0;
                r_sat <= 1'b0;
            end else if (r_tag_vld && (r_tag_k == KW'(g))) begin
                r_sum <= w_next;
                if (w_ovf) r_sat <= 1'b1;
            end
        end

        assign o_sums[g*SUM_WIDTH +: SUM_WIDTH] = r_sum;
        assign o_sat[g]                         = r_sat;
    end

endmodule

// File: tb/tb_synapse_accum_engine.sv
// Bench for synapse_accum_engine. Four instances cover the parameter sets:
//   A: NUM_OUT=1 unsigned, B: NUM_OUT=4 signed, C: SUM_WIDTH=8 signed NUM_OUT=1,
//   D: NUM_OUT=4 with a 4-bit memory address.
// Cycle c is the clock period ending at rising edge c; start is sampled at edge 0.
module tb_synapse_accum_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] st;
    int         total = 0;
    int         bad   = 0;
    int         sel   = 0;

    logic [13:0] a_fd, b_fd, c_fd, d_fd;
    logic        a_fv, b_fv, c_fv, d_fv;
    logic        a_rden, b_rden, c_rden, d_rden;
    logic        a_en, b_en, c_en, d_en;
    logic [15:0] a_addr, b_addr, c_addr;
    logic [3:0]  d_addr;
    logic [7:0]  a_rd, b_rd, c_rd, d_rd;
    logic [15:0] a_sums;
    logic [63:0] b_sums, d_sums;
    logic [7:0]  c_sums;
    logic [0:0]  a_sat, c_sat;
    logic [3:0]  b_sat, d_sat;
    logic        a_busy, b_busy, c_busy, d_busy;
    logic        a_done, b_done, c_done, d_done;

    synapse_accum_engine #(.NUM_OUT(1), .SIGNED_WEIGHTS(0)) u_a (
        .clk(clk), .rst(rst), .i_start(st[0]), .i_fifo_data(a_fd), .i_fifo_valid(a_fv),
        .o_fifo_rden(a_rden), .o_mem_addr(a_addr), .o_mem_en(a_en), .i_mem_rdata(a_rd),
        .o_sums(a_sums), .o_sat(a_sat), .o_busy(a_busy), .o_done(a_done));
    synapse_accum_engine #(.NUM_OUT(4), .SIGNED_WEIGHTS(1)) u_b (
        .clk(clk), .rst(rst), .i_start(st[1]), .i_fifo_data(b_fd), .i_fifo_valid(b_fv),
        .o_fifo_rden(b_rden), .o_mem_addr(b_addr), .o_mem_en(b_en), .i_mem_rdata(b_rd),
        .o_sums(b_sums), .o_sat(b_sat), .o_busy(b_busy), .o_done(b_done));
    synapse_accum_engine #(.NUM_OUT(1), .SUM_WIDTH(8), .SIGNED_WEIGHTS(1)) u_c (
        .clk(clk), .rst(rst), .i_start(st[2]), .i_fifo_data(c_fd), .i_fifo_valid(c_fv),
        .o_fifo_rden(c_rden), .o_mem_addr(c_addr), .o_mem_en(c_en), .i_mem_rdata(c_rd),
        .o_sums(c_sums), .o_sat(c_sat), .o_busy(c_busy), .o_done(c_done));
    synapse_accum_engine #(.NUM_OUT(4), .MEM_ADDR_WIDTH(4), .SIGNED_WEIGHTS(1)) u_d (
        .clk(clk), .rst(rst), .i_start(st[3]), .i_fifo_data(d_fd), .i_fifo_valid(d_fv),
        .o_fifo_rden(d_rden), .o_mem_addr(d_addr), .o_mem_en(d_en), .i_mem_rdata(d_rd),
        .o_sums(d_sums), .o_sat(d_sat), .o_busy(d_busy), .o_done(d_done));

    // Memory models: address captured mid-cycle, data presented after the next edge.
    logic [7:0]  mem_a [65536];
    logic [7:0]  mem_b [65536];
    logic [7:0]  mem_c [65536];
    logic [7:0]  mem_d [16];
    logic [15:0] ra, rb, rc;
    logic [3:0]  rdd;
    always @(negedge clk) begin
        ra = a_addr; rb = b_addr; rc = c_addr; rdd = d_addr;
    end
    always @(posedge clk) begin
        a_rd <= mem_a[ra]; b_rd <= mem_b[rb]; c_rd <= mem_c[rc]; d_rd <= mem_d[rdd];
    end

    // Show-ahead FIFO models: pop requests seen mid-cycle, applied just after the edge.
    logic [13:0] qa[$], qb[$], qc[$], qd[$];
    logic [3:0]  pend;

    task automatic refresh();
        a_fv = (qa.size() > 0); a_fd = a_fv ? qa[0] : 14'd0;
        b_fv = (qb.size() > 0); b_fd = b_fv ? qb[0] : 14'd0;
        c_fv = (qc.size() > 0); c_fd = c_fv ? qc[0] : 14'd0;
        d_fv = (qd.size() > 0); d_fd = d_fv ? qd[0] : 14'd0;
    endtask

    always @(negedge clk) pend = {d_rden, c_rden, b_rden, a_rden};
    always @(posedge clk) begin
        #1;
        if (pend[0]) void'(qa.pop_front());
        if (pend[1]) void'(qb.pop_front());
        if (pend[2]) void'(qc.pop_front());
        if (pend[3]) void'(qd.pop_front());
        refresh();
    end

    task automatic push(input int s, input logic [13:0] v);
        case (s)
            0: qa.push_back(v);
            1: qb.push_back(v);
            2: qc.push_back(v);
            default: qd.push_back(v);
        endcase
        refresh();
    endtask

    function automatic int qsize(input int s);
        case (s)
            0: return qa.size();
            1: return qb.size();
            2: return qc.size();
            default: return qd.size();
        endcase
    endfunction

    function automatic int nout(input int s);
        return (s == 1 || s == 3) ? 4 : 1;
    endfunction

    // Observation mux over the selected instance.
    logic        o_rden, o_en, o_busy, o_done;
    logic [15:0] o_addr;
    logic [63:0] o_sums;
    logic [3:0]  o_sat;
    always_comb begin
        o_rden = a_rden; o_en = a_en; o_addr = a_addr; o_sums = {48'd0, a_sums};
        o_sat = {3'd0, a_sat}; o_busy = a_busy; o_done = a_done;
        case (sel)
            1: begin
                o_rden = b_rden; o_en = b_en; o_addr = b_addr; o_sums = b_sums;
                o_sat = b_sat; o_busy = b_busy; o_done = b_done;
            end
            2: begin
                o_rden = c_rden; o_en = c_en; o_addr = c_addr; o_sums = {56'd0, c_sums};
                o_sat = {3'd0, c_sat}; o_busy = c_busy; o_done = c_done;
            end
            3: begin
                o_rden = d_rden; o_en = d_en; o_addr = {12'd0, d_addr}; o_sums = d_sums;
                o_sat = d_sat; o_busy = d_busy; o_done = d_done;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        int               sel;
        int               nsp;
        logic [0:3][13:0] sp;
        int               ign;
        logic [63:0]      sums;
        logic [3:0]       sat;
        int               done;
        int               npop;
        int               naddr;
        logic [0:7][15:0] addr;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int          dcyc, npop, nadr, n;
        int          popc[8];
        logic [15:0] adrs[16];
        logic [63:0] sums_d;
        logic [3:0]  sat_d;
        logic        busy_d;
        sums_d = '0; sat_d = '0; busy_d = 1'b0;
        for (int i = 0; i < 8; i++) popc[i] = 0;
        for (int i = 0; i < 16; i++) adrs[i] = '0;
        sel = v.sel;
        n   = nout(v.sel);
        @(negedge clk);
        for (int i = 0; i < v.nsp; i++) push(v.sel, v.sp[i]);
        st[v.sel] = 1'b1;
        dcyc = -1; npop = 0; nadr = 0;
        for (int c = 1; c <= 60 && dcyc < 0; c++) begin
            @(negedge clk);
            st[v.sel] = (c == v.ign);
            if (c == 1) chk($sformatf("v%0d_busy_c1", idx), {63'd0, o_busy}, 64'd1);
            if (o_rden) begin
                if (npop < 8) popc[npop] = c;
                npop++;
            end
            if (o_en) begin
                if (nadr < 16) adrs[nadr] = o_addr;
                nadr++;
            end
            if (o_done) begin
                dcyc = c; sums_d = o_sums; sat_d = o_sat; busy_d = o_busy;
            end
        end
        st = '0;
        chk($sformatf("v%0d_done_cyc", idx), 64'(dcyc), 64'(v.done));
        chk($sformatf("v%0d_sums", idx), sums_d, v.sums);
        chk($sformatf("v%0d_sat", idx), {60'd0, sat_d}, {60'd0, v.sat});
        chk($sformatf("v%0d_busy_done", idx), {63'd0, busy_d}, 64'd1);
        @(negedge clk);
        chk($sformatf("v%0d_busy_after", idx), {62'd0, o_busy, o_done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_sums_hold", idx), o_sums, v.sums);
        chk($sformatf("v%0d_sat_hold", idx), {60'd0, o_sat}, {60'd0, v.sat});
        chk($sformatf("v%0d_npop", idx), 64'(npop), 64'(v.npop));
        for (int i = 0; i < npop && i < 8; i++)
            chk($sformatf("v%0d_pop%0d_cyc", idx, i), 64'(popc[i]), 64'(1 + i * (n + 1)));
        chk($sformatf("v%0d_naddr", idx), 64'(nadr), 64'(v.naddr));
        for (int i = 0; i < v.naddr && i < 8; i++)
            chk($sformatf("v%0d_addr%0d", idx, i), {48'd0, adrs[i]}, {48'd0, v.addr[i]});
        chk($sformatf("v%0d_fifo_left", idx), 64'(qsize(v.sel)), 64'd0);
    endtask

    vec_t tbl[8];
    vec_t vr;

    initial begin
        rst = 1'b1;
        st  = '0;
        for (int i = 0; i < 65536; i++) begin
            mem_a[i] = 8'h00; mem_b[i] = 8'h00; mem_c[i] = 8'h00;
        end
        for (int i = 0; i < 16; i++) mem_d[i] = 8'(i + 1);
        mem_a[10] = 8'hAA; mem_a[20] = 8'hBB; mem_a[30] = 8'hCC;
        mem_b[4]  = 8'h11; mem_b[5]  = 8'h22; mem_b[6]  = 8'h33; mem_b[7]  = 8'h44;
        mem_b[8]  = 8'h01; mem_b[9]  = 8'h02; mem_b[10] = 8'h03; mem_b[11] = 8'h04;
        mem_b[20] = 8'hFF; mem_b[21] = 8'h10; mem_b[22] = 8'h80; mem_b[23] = 8'h00;
        mem_c[1]  = 8'h7F; mem_c[2]  = 8'h80;
        refresh();

        tbl[0] = '{sel:0, nsp:3, sp:{14'd10, 14'd20, 14'd30, 14'd0}, ign:0,
                   sums:64'h0231, sat:4'h0, done:8, npop:3, naddr:3,
                   addr:{16'd10, 16'd20, 16'd30, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
        tbl[1] = '{sel:1, nsp:2, sp:{14'd2, 14'd5, 14'd0, 14'd0}, ign:0,
                   sums:64'h0004_FF83_0012_0000, sat:4'h0, done:12, npop:2, naddr:8,
                   addr:{16'd8, 16'd9, 16'd10, 16'd11, 16'd20, 16'd21, 16'd22, 16'd23}};
        tbl[2] = '{sel:1, nsp:0, sp:'0, ign:0,
                   sums:64'h0, sat:4'h0, done:2, npop:0, naddr:0, addr:'0};
        tbl[3] = '{sel:1, nsp:1, sp:{14'd2, 14'd0, 14'd0, 14'd0}, ign:3,
                   sums:64'h0004_0003_0002_0001, sat:4'h0, done:7, npop:1, naddr:4,
                   addr:{16'd8, 16'd9, 16'd10, 16'd11, 16'd0, 16'd0, 16'd0, 16'd0}};
        tbl[4] = '{sel:2, nsp:4, sp:{14'd1, 14'd1, 14'd1, 14'd1}, ign:0,
                   sums:64'h7F, sat:4'h1, done:10, npop:4, naddr:4,
                   addr:{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0}};
        tbl[5] = '{sel:2, nsp:4, sp:{14'd2, 14'd2, 14'd2, 14'd2}, ign:0,
                   sums:64'h80, sat:4'h1, done:10, npop:4, naddr:4,
                   addr:{16'd2, 16'd2, 16'd2, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0}};
        tbl[6] = '{sel:2, nsp:0, sp:'0, ign:0,
                   sums:64'h0, sat:4'h0, done:2, npop:0, naddr:0, addr:'0};
        tbl[7] = '{sel:3, nsp:2, sp:{14'd3, 14'd4, 14'd0, 14'd0}, ign:0,
                   sums:64'h0014_0012_0010_000E, sat:4'h0, done:12, npop:2, naddr:8,
                   addr:{16'd12, 16'd13, 16'd14, 16'd15, 16'd0, 16'd1, 16'd2, 16'd3}};

        // Reset state, both while held and after release.
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s; #1;
            chk($sformatf("rst_held_%0d", s),
                {o_rden, o_en, o_addr, o_sat, o_busy, o_done} | o_sums, 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s; #1;
            chk($sformatf("rst_rel_%0d", s),
                {o_rden, o_en, o_addr, o_sat, o_busy, o_done} | o_sums, 64'd0);
        end

        for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

        // Reset during a READ of the second of three spikes.
        sel = 1;
        @(negedge clk);
        push(1, 14'd5); push(1, 14'd2); push(1, 14'd1);
        st[1] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            st[1] = 1'b0;
        end
        chk("mid_was_read", {63'd0, o_en}, 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_no_rd", {62'd0, o_en, o_rden}, 64'd0);
        @(negedge clk);
        chk("mid_rst_outs", {o_rden, o_en, o_addr, o_sat, o_busy, o_done} | o_sums, 64'd0);
        chk("mid_rst_fifo", 64'(qsize(1)), 64'd1);
        rst = 1'b0;
        vr = '{sel:1, nsp:0, sp:'0, ign:0,
               sums:64'h0044_0033_0022_0011, sat:4'h0, done:7, npop:1, naddr:4,
               addr:{16'd4, 16'd5, 16'd6, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0}};
        run_vec(8, vr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
